// File: rtl/fifo_mem.sv
// fifo_mem: 2**ASIZE x DSIZE storage, one synchronous write port, one combinational read port.
// No reset on contents; maps to distributed RAM or flops.
module fifo_mem #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (wclken) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through FIFO; a write is visible on rdata one edge later.
// Backpressure: winc is dropped while wfull, rinc is dropped while rempty; no pass-through.
module fifo #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic [DSIZE-1:0] rdata,
  input  logic             rinc,
  output logic             rempty
);

  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           wen;
  logic           ren;

  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                  (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) begin
        wptr <= wptr + PTR_ONE;
      end
      if (ren) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk    (clk),
    .wclken (wen),
    .waddr  (wptr[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr[ASIZE-1:0]),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed and randomized stimulus for fifo, checked each cycle against a queue model.
module tb_fifo;

  localparam int DSIZE = 32;
  localparam int ASIZE = 4;
  localparam int DEPTH = 2**ASIZE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DSIZE-1:0] wdata = '0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic             wfull;
  logic             rempty;
  logic [DSIZE-1:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [DSIZE-1:0] q [$];

  fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .reset  (reset),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rdata  (rdata),
    .rinc   (rinc),
    .rempty (rempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words, decisions taken on pre-edge occupancy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      automatic bit do_w = winc && (q.size() < DEPTH);
      automatic bit do_r = rinc && (q.size() > 0);
      if (do_r) void'(q.pop_front());
      if (do_w) q.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    chk("rempty_model", {31'b0, rempty}, {31'b0, q.size() == 0});
    chk("wfull_model", {31'b0, wfull}, {31'b0, q.size() == DEPTH});
    if (q.size() > 0) chk("rdata_model", rdata, q[0]);
  end

  task automatic cyc(input logic w, input logic [DSIZE-1:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_rempty", {31'b0, rempty}, 32'd1);
    chk("reset_wfull", {31'b0, wfull}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fill_not_full_15", {31'b0, wfull}, 32'd0);
      cyc(1'b1, i, 1'b0);
    end
    chk("fill_wfull", {31'b0, wfull}, 32'd1);
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    chk("overflow_wfull", {31'b0, wfull}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_rdata", rdata, i);
      cyc(1'b0, '0, 1'b1);
    end
    chk("drain_rempty", {31'b0, rempty}, 32'd1);

    // Underflow then write.
    cyc(1'b0, '0, 1'b1);
    chk("underflow_rempty", {31'b0, rempty}, 32'd1);
    cyc(1'b1, 32'h12345678, 1'b0);
    chk("after_underflow_rdata", rdata, 32'h12345678);
    chk("after_underflow_rempty", {31'b0, rempty}, 32'd0);
    cyc(1'b0, '0, 1'b1);

    // Simultaneous push/pop with 3 entries.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + i, 1'b0);
    cyc(1'b1, 32'h103, 1'b1);
    chk("simul3_head", rdata, 32'h101);
    for (int i = 0; i < 3; i++) begin
      chk("simul3_drain", rdata, 32'h101 + i);
      cyc(1'b0, '0, 1'b1);
    end
    chk("simul3_rempty", {31'b0, rempty}, 32'd1);

    // Simultaneous push/pop when full: write dropped.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h200 + i, 1'b0);
    cyc(1'b1, 32'h999, 1'b1);
    chk("simulfull_wfull", {31'b0, wfull}, 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("simulfull_drain", rdata, 32'h200 + i);
      cyc(1'b0, '0, 1'b1);
    end
    chk("simulfull_rempty", {31'b0, rempty}, 32'd1);

    // FWFT latency.
    cyc(1'b1, 32'hCAFEF00D, 1'b0);
    chk("fwft_rdata", rdata, 32'hCAFEF00D);
    chk("fwft_rempty", {31'b0, rempty}, 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("fwft_pop_rempty", {31'b0, rempty}, 32'd1);

    // Asynchronous reset with 5 entries stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + i, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_rempty", {31'b0, rempty}, 32'd1);
    chk("midreset_wfull", {31'b0, wfull}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b0, '0, 1'b1);
    chk("postreset_rinc_rempty", {31'b0, rempty}, 32'd1);

    // Random rolling stream, alternating write-heavy and read-heavy phases to hit both flags.
    for (int i = 0; i < 800; i++) begin
      automatic int pw = ((i / 100) % 2 == 0) ? 75 : 30;
      cyc($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < (100 - pw));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
